// File: rtl/dbus_xbar_pkg.sv
// Shared constants and types for the CPU data-bus crossbar.
// Default memory map, rsel encoding and the offset-mask helper.
package dbus_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [31:0] IRAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] DRAM_BASE    = 32'h0100_0000;
    localparam logic [31:0] UART_BASE    = 32'h0200_0000;
    localparam logic [31:0] SEG_BASE     = 32'h0300_0000;
    localparam logic [31:0] SEC_CLK_BASE = 32'h0400_0000;
    localparam logic [31:0] BUTTON_BASE  = 32'h0500_0000;

    localparam logic [7:0] IRAM_AW    = 8'd14;
    localparam logic [7:0] DRAM_AW    = 8'd14;
    localparam logic [7:0] UART_AW    = 8'd8;
    localparam logic [7:0] SEG_AW     = 8'd4;
    localparam logic [7:0] SEC_CLK_AW = 8'd4;
    localparam logic [7:0] BUTTON_AW  = 8'd4;

    localparam logic [6*32-1:0] DEFAULT_BASEADDRS = {
        BUTTON_BASE, SEC_CLK_BASE, SEG_BASE,
        UART_BASE, DRAM_BASE, IRAM_BASE
    };

    localparam logic [6*8-1:0] DEFAULT_SLAVE_AW = {
        BUTTON_AW, SEC_CLK_AW, SEG_AW,
        UART_AW, DRAM_AW, IRAM_AW
    };

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_HIT  = 2'd1,
        RSEL_MISS = 2'd2
    } rsel_st_e;

    typedef struct packed {
        rsel_st_e   st;
        logic [3:0] idx;
    } rsel_t;

    function automatic logic [ADDR_W-1:0] aw_mask(input logic [7:0] aw);
        if (aw >= 8'd32) return '1;
        return (ADDR_W'(1) << aw) - ADDR_W'(1);
    endfunction

endpackage

// File: rtl/dbus_xbar_if.sv
// CPU-side and slave-side signals of the data-bus crossbar.
// slave = the crossbar's view, master = the surrounding system.
interface dbus_xbar_if #(
    parameter int NSLAVE = 6
);
    logic                 m_wr;
    logic [31:0]          m_waddr;
    logic [31:0]          m_wdata;
    logic [3:0]           m_wstrb;
    logic                 m_rd;
    logic [31:0]          m_raddr;
    logic [31:0]          m_rdata;
    logic                 m_rerr;
    logic [NSLAVE-1:0]    s_wr;
    logic [31:0]          s_waddr;
    logic [31:0]          s_wdata;
    logic [3:0]           s_wstrb;
    logic [NSLAVE-1:0]    s_rd;
    logic [31:0]          s_raddr;
    logic [NSLAVE*32-1:0] s_rdata;

    modport slave (
        input  m_wr, m_waddr, m_wdata, m_wstrb,
        input  m_rd, m_raddr, s_rdata,
        output m_rdata, m_rerr,
        output s_wr, s_waddr, s_wdata, s_wstrb,
        output s_rd, s_raddr
    );

    modport master (
        output m_wr, m_waddr, m_wdata, m_wstrb,
        output m_rd, m_raddr, s_rdata,
        input  m_rdata, m_rerr,
        input  s_wr, s_waddr, s_wdata, s_wstrb,
        input  s_rd, s_raddr
    );
endinterface

// File: rtl/dbus_xbar_decode.sv
// Combinational address decoder: one-hot hit vector (lowest index
// wins), hit flag and the offset masked to the winner's width.
module dbus_decode import dbus_pkg::*; #(
    parameter int                   NSLAVE         = 6,
    parameter int                   BASEADDR_WIDTH = 8,
    parameter logic [NSLAVE*32-1:0] BASEADDRS      = DEFAULT_BASEADDRS,
    parameter logic [NSLAVE*8-1:0]  SLAVE_AW       = DEFAULT_SLAVE_AW,
    parameter bit                   STRICT         = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NSLAVE-1:0] hit_vec,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    localparam logic [ADDR_W-1:0] TOP_MASK =
        ~({ADDR_W{1'b1}} >> BASEADDR_WIDTH);

    logic [ADDR_W-1:0] base_i;
    logic [ADDR_W-1:0] mask_i;
    logic              raw;

    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        offset  = '0;
        base_i  = '0;
        mask_i  = '0;
        raw     = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            base_i = BASEADDRS[32*i +: 32];
            mask_i = aw_mask(SLAVE_AW[8*i +: 8]);
            raw    = ((addr ^ base_i) & TOP_MASK) == '0;
            // Bits between the offset and the base field must be clear.
            if (STRICT)
                raw = raw && ((addr & ~mask_i & ~TOP_MASK) == '0);
            if (raw && !hit) begin
                hit        = 1'b1;
                hit_vec[i] = 1'b1;
                offset     = addr & mask_i;
            end
        end
    end

endmodule

// File: rtl/dbus_xbar.sv
// CPU data-bus crossbar: decodes read/write onto NSLAVE slaves,
// returns read data through a registered select, logs unmapped hits.
module dbus_xbar import dbus_pkg::*; #(
    parameter int                   NSLAVE         = 6,
    parameter int                   BASEADDR_WIDTH = 8,
    parameter logic [NSLAVE*32-1:0] BASEADDRS      = DEFAULT_BASEADDRS,
    parameter logic [NSLAVE*8-1:0]  SLAVE_AW       = DEFAULT_SLAVE_AW,
    parameter bit                   STRICT         = 1'b1,
    parameter logic [DATA_W-1:0]    ERR_DATA       = DEFAULT_ERR_DATA,
    parameter int                   ERRCNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    dbus_xbar_if.slave          bus,
    input  logic                err_clr,
    output logic                err_valid,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                err_wr,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int CW = ERRCNT_W + 1;

    logic [NSLAVE-1:0] w_vec, r_vec;
    logic              w_hit, r_hit;
    logic [ADDR_W-1:0] w_off, r_off;
    logic [3:0]        r_idx;

    rsel_t rsel_d, rsel_q;

    logic                err_valid_d, err_valid_q;
    logic [ADDR_W-1:0]   err_addr_d, err_addr_q;
    logic                err_wr_d, err_wr_q;
    logic [ERRCNT_W-1:0] err_cnt_d, err_cnt_q;

    logic                werr, rerr;
    logic [ERRCNT_W-1:0] cnt_base;
    logic [CW-1:0]       cnt_sum;
    logic                valid_base;

    dbus_decode #(
        .NSLAVE(NSLAVE), .BASEADDR_WIDTH(BASEADDR_WIDTH),
        .BASEADDRS(BASEADDRS), .SLAVE_AW(SLAVE_AW), .STRICT(STRICT)
    ) u_dec_w (
        .addr(bus.m_waddr), .hit_vec(w_vec), .hit(w_hit), .offset(w_off)
    );

    dbus_decode #(
        .NSLAVE(NSLAVE), .BASEADDR_WIDTH(BASEADDR_WIDTH),
        .BASEADDRS(BASEADDRS), .SLAVE_AW(SLAVE_AW), .STRICT(STRICT)
    ) u_dec_r (
        .addr(bus.m_raddr), .hit_vec(r_vec), .hit(r_hit), .offset(r_off)
    );

    always_comb begin
        r_idx = '0;
        for (int i = 0; i < NSLAVE; i++)
            if (r_vec[i]) r_idx = 4'(i);
    end

    // Issue side: pure decode, gated by reset.
    always_comb begin
        bus.s_wr    = (bus.m_wr && !rst) ? w_vec : '0;
        bus.s_waddr = w_off;
        bus.s_wdata = bus.m_wdata;
        bus.s_wstrb = bus.m_wstrb;
        bus.s_rd    = (bus.m_rd && !rst) ? r_vec : '0;
        bus.s_raddr = r_off;
    end

    always_comb begin
        rsel_d = '{st: RSEL_NONE, idx: 4'd0};
        if (bus.m_rd) begin
            if (r_hit) rsel_d = '{st: RSEL_HIT, idx: r_idx};
            else       rsel_d = '{st: RSEL_MISS, idx: 4'd0};
        end
    end

    always_comb begin
        bus.m_rdata = '0;
        bus.m_rerr  = 1'b0;
        case (rsel_q.st)
            RSEL_HIT:  bus.m_rdata = bus.s_rdata[32*rsel_q.idx +: 32];
            RSEL_MISS: begin
                bus.m_rdata = ERR_DATA;
                bus.m_rerr  = 1'b1;
            end
            default: ;
        endcase
    end

    // Clear is applied first so a same-cycle error lands on a fresh log.
    always_comb begin
        werr       = bus.m_wr && !w_hit && !rst;
        rerr       = bus.m_rd && !r_hit && !rst;
        cnt_base   = err_clr ? '0 : err_cnt_q;
        valid_base = err_clr ? 1'b0 : err_valid_q;
        err_addr_d = err_clr ? '0 : err_addr_q;
        err_wr_d   = err_clr ? 1'b0 : err_wr_q;
        cnt_sum    = {1'b0, cnt_base} + CW'(werr) + CW'(rerr);
        err_cnt_d  = cnt_sum[ERRCNT_W] ? '1 : cnt_sum[ERRCNT_W-1:0];
        if ((werr || rerr) && !valid_base) begin
            err_addr_d = werr ? bus.m_waddr : bus.m_raddr;
            err_wr_d   = werr;
        end
        err_valid_d = valid_base || werr || rerr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsel_q      <= '{st: RSEL_NONE, idx: 4'd0};
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_wr_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rsel_q      <= rsel_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_wr_q    <= err_wr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_wr    = err_wr_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dbus_xbar.sv
// Scoreboard bench for dbus_xbar: a strict/16-bit-counter instance (a)
// and an aliasing/2-bit-counter instance (b) share one stimulus stream.
module tb_dbus_xbar;
    import dbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst, err_clr;
    logic        m_wr, m_rd;
    logic [31:0] m_waddr, m_wdata, m_raddr;
    logic [3:0]  m_wstrb;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_xbar_if #(.NSLAVE(6)) ifa ();
    dbus_xbar_if #(.NSLAVE(6)) ifb ();

    assign ifa.m_wr = m_wr;       assign ifb.m_wr = m_wr;
    assign ifa.m_waddr = m_waddr; assign ifb.m_waddr = m_waddr;
    assign ifa.m_wdata = m_wdata; assign ifb.m_wdata = m_wdata;
    assign ifa.m_wstrb = m_wstrb; assign ifb.m_wstrb = m_wstrb;
    assign ifa.m_rd = m_rd;       assign ifb.m_rd = m_rd;
    assign ifa.m_raddr = m_raddr; assign ifb.m_raddr = m_raddr;

    logic        a_ev, a_ew, b_ev, b_ew;
    logic [31:0] a_ea, b_ea;
    logic [15:0] a_ec;
    logic [1:0]  b_ec;

    dbus_xbar u_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .err_clr(err_clr),
        .err_valid(a_ev), .err_addr(a_ea), .err_wr(a_ew), .err_cnt(a_ec)
    );

    dbus_xbar #(.STRICT(1'b0), .ERRCNT_W(2)) u_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .err_clr(err_clr),
        .err_valid(b_ev), .err_addr(b_ea), .err_wr(b_ew), .err_cnt(b_ec)
    );

    // Slave models: 1-cycle latency, data = tag ^ offset.
    logic [31:0] tag [6] = '{32'h1111_0000, 32'h1234_5668, 32'h2222_0000,
                             32'h3333_0000, 32'h4444_0000, 32'h5555_0000};
    logic [31:0] sdat_a [6];
    logic [31:0] sdat_b [6];

    always @(posedge clk)
        for (int i = 0; i < 6; i++) begin
            if (ifa.s_rd[i]) sdat_a[i] <= tag[i] ^ ifa.s_raddr;
            if (ifb.s_rd[i]) sdat_b[i] <= tag[i] ^ ifb.s_raddr;
        end

    for (genvar g = 0; g < 6; g++) begin : g_sl
        assign ifa.s_rdata[32*g +: 32] = sdat_a[g];
        assign ifb.s_rdata[32*g +: 32] = sdat_b[g];
    end

    typedef enum {
        K_SWR, K_SWADDR, K_SWDATA, K_SWSTRB, K_SRD, K_SRADDR,
        K_RDATA, K_RERR, K_EVALID, K_EADDR, K_EWR, K_ECNT,
        K_B_SRD, K_B_SRADDR, K_B_ECNT, K_B_EVALID, K_B_EADDR, K_B_EWR
    } kind_e;

    typedef struct {
        int          due;
        kind_e       k;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] actual(kind_e k);
        case (k)
            K_SWR:      return {26'b0, ifa.s_wr};
            K_SWADDR:   return ifa.s_waddr;
            K_SWDATA:   return ifa.s_wdata;
            K_SWSTRB:   return {28'b0, ifa.s_wstrb};
            K_SRD:      return {26'b0, ifa.s_rd};
            K_SRADDR:   return ifa.s_raddr;
            K_RDATA:    return ifa.m_rdata;
            K_RERR:     return {31'b0, ifa.m_rerr};
            K_EVALID:   return {31'b0, a_ev};
            K_EADDR:    return a_ea;
            K_EWR:      return {31'b0, a_ew};
            K_ECNT:     return {16'b0, a_ec};
            K_B_SRD:    return {26'b0, ifb.s_rd};
            K_B_SRADDR: return ifb.s_raddr;
            K_B_ECNT:   return {30'b0, b_ec};
            K_B_EVALID: return {31'b0, b_ev};
            K_B_EADDR:  return b_ea;
            K_B_EWR:    return {31'b0, b_ew};
            default:    return 32'hx;
        endcase
    endfunction

    // Monitor: compares every expectation whose due cycle has come.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.k);
            checks++;
            if (e.due < cyc) begin
                errors++;
                $display("FAIL %s stale due=%0d cyc=%0d", e.k.name(), e.due, cyc);
            end else if (act !== e.v) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", e.k.name(), cyc, act, e.v);
            end
        end
        if (done && sb.size() > 0) begin
            errors++;
            $display("FAIL leftover %0d expectations never checked", sb.size());
            sb.delete();
        end
    end

    task automatic exp_at(input int d, input kind_e k, input logic [31:0] v);
        sb.push_back('{d, k, v});
    endtask

    task automatic drive(input logic wr, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input logic rd, input logic [31:0] ra,
                         input logic clr, input logic r);
        m_wr = wr; m_waddr = wa; m_wdata = wd; m_wstrb = ws;
        m_rd = rd; m_raddr = ra; err_clr = clr; rst = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        drive(1, 32'h0100_0000, 32'h1, 4'hF, 1, 32'h0, 0, 1);
        tick; c = cyc;
        exp_at(c, K_SWR, 0); exp_at(c, K_SRD, 0); exp_at(c, K_B_SRD, 0);
        tick; c = cyc;
        exp_at(c, K_EVALID, 0); exp_at(c, K_ECNT, 0);
        exp_at(c, K_EADDR, 0);  exp_at(c, K_EWR, 0);
        exp_at(c, K_RDATA, 0);  exp_at(c, K_RERR, 0);
        exp_at(c, K_B_ECNT, 0);

        // DRAM read
        drive(0, 0, 0, 0, 1, 32'h0100_0010, 0, 0);
        exp_at(c, K_SRD, 6'b000010); exp_at(c, K_SRADDR, 32'h10);
        exp_at(c + 1, K_RDATA, 32'h1234_5678); exp_at(c + 1, K_RERR, 0);
        tick; c = cyc;

        // SEG write
        drive(1, 32'h0300_0004, 32'hA5, 4'hF, 0, 0, 0, 0);
        exp_at(c, K_SWR, 6'b001000); exp_at(c, K_SWADDR, 32'h4);
        exp_at(c, K_SWDATA, 32'hA5); exp_at(c, K_SWSTRB, 32'hF);
        exp_at(c, K_SRD, 0);
        exp_at(c + 1, K_RDATA, 0); exp_at(c + 1, K_RERR, 0);
        tick; c = cyc;

        // Stray bits below the base field: miss when strict, alias when not
        drive(0, 0, 0, 0, 1, 32'h0300_0100, 0, 0);
        exp_at(c, K_SRD, 0); exp_at(c, K_SRADDR, 0);
        exp_at(c, K_B_SRD, 6'b001000); exp_at(c, K_B_SRADDR, 0);
        exp_at(c + 1, K_RDATA, 32'hDEAD_BEEF); exp_at(c + 1, K_RERR, 1);
        exp_at(c + 1, K_EVALID, 1); exp_at(c + 1, K_EADDR, 32'h0300_0100);
        exp_at(c + 1, K_EWR, 0); exp_at(c + 1, K_ECNT, 1);
        exp_at(c + 1, K_B_ECNT, 0);
        tick; c = cyc;

        // Double miss while already logged: count +2, first address kept
        drive(1, 32'h0700_0000, 0, 4'hF, 1, 32'h0800_0000, 0, 0);
        exp_at(c, K_SWR, 0); exp_at(c, K_SWADDR, 0);
        exp_at(c + 1, K_ECNT, 3); exp_at(c + 1, K_EADDR, 32'h0300_0100);
        exp_at(c + 1, K_EWR, 0); exp_at(c + 1, K_B_ECNT, 2);
        tick; c = cyc;

        drive(0, 0, 0, 0, 0, 0, 1, 0);
        exp_at(c + 1, K_EVALID, 0); exp_at(c + 1, K_ECNT, 0);
        exp_at(c + 1, K_EADDR, 0);  exp_at(c + 1, K_B_ECNT, 0);
        tick; c = cyc;

        // Write and read miss together on an empty log: write captured
        drive(1, 32'h0700_0000, 0, 4'hF, 1, 32'h0800_0000, 0, 0);
        exp_at(c + 1, K_ECNT, 2); exp_at(c + 1, K_EADDR, 32'h0700_0000);
        exp_at(c + 1, K_EWR, 1);  exp_at(c + 1, K_EVALID, 1);
        exp_at(c + 1, K_RERR, 1); exp_at(c + 1, K_B_ECNT, 2);
        tick; c = cyc;

        // Clear with a same-cycle miss
        drive(0, 0, 0, 0, 1, 32'h0900_0000, 1, 0);
        exp_at(c + 1, K_ECNT, 1); exp_at(c + 1, K_EADDR, 32'h0900_0000);
        exp_at(c + 1, K_EVALID, 1); exp_at(c + 1, K_EWR, 0);
        exp_at(c + 1, K_B_ECNT, 1);
        tick; c = cyc;

        // Five unmapped writes: b saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h0A00_0000, 0, 4'hF, 0, 0, 0, 0);
            exp_at(c, K_SWR, 0);
            exp_at(c + 1, K_B_ECNT, (i == 0) ? 2 : 3);
            exp_at(c + 1, K_ECNT, 2 + i);
            if (i == 0) begin
                exp_at(c + 1, K_B_EVALID, 1);
                exp_at(c + 1, K_B_EADDR, 32'h0900_0000);
                exp_at(c + 1, K_B_EWR, 0);
            end
            tick; c = cyc;
        end

        // Back-to-back reads: IRAM, UART, miss, DRAM
        drive(0, 0, 0, 0, 1, 32'h0000_0020, 0, 0);
        exp_at(c, K_SRD, 6'b000001); exp_at(c, K_SRADDR, 32'h20);
        exp_at(c + 1, K_RDATA, 32'h1111_0020); exp_at(c + 1, K_RERR, 0);
        tick; c = cyc;
        drive(0, 0, 0, 0, 1, 32'h0200_0005, 0, 0);
        exp_at(c, K_SRD, 6'b000100); exp_at(c, K_SRADDR, 32'h5);
        exp_at(c + 1, K_RDATA, 32'h2222_0005); exp_at(c + 1, K_RERR, 0);
        tick; c = cyc;
        drive(0, 0, 0, 0, 1, 32'h0600_0000, 0, 0);
        exp_at(c, K_SRD, 0);
        exp_at(c + 1, K_RDATA, 32'hDEAD_BEEF); exp_at(c + 1, K_RERR, 1);
        exp_at(c + 1, K_ECNT, 7);
        tick; c = cyc;
        drive(0, 0, 0, 0, 1, 32'h0100_0000, 0, 0);
        exp_at(c, K_SRD, 6'b000010);
        exp_at(c + 1, K_RDATA, 32'h1234_5668); exp_at(c + 1, K_RERR, 0);
        tick; c = cyc;

        // Read and write to the same slave in one cycle
        drive(1, 32'h0100_0008, 32'h55, 4'h3, 1, 32'h0100_0004, 0, 0);
        exp_at(c, K_SWR, 6'b000010); exp_at(c, K_SWADDR, 32'h8);
        exp_at(c, K_SWSTRB, 32'h3);
        exp_at(c, K_SRD, 6'b000010); exp_at(c, K_SRADDR, 32'h4);
        exp_at(c + 1, K_RDATA, 32'h1234_566C);
        tick; c = cyc;

        // UART read, then reset: data still returned in the reset cycle
        drive(0, 0, 0, 0, 1, 32'h0200_0010, 0, 0);
        exp_at(c + 1, K_RDATA, 32'h2222_0010); exp_at(c + 1, K_RERR, 0);
        tick; c = cyc;
        drive(1, 32'h0F00_0000, 0, 4'hF, 1, 32'h0000_0000, 0, 1);
        exp_at(c, K_SRD, 0); exp_at(c, K_SWR, 0);
        tick; c = cyc;
        drive(0, 0, 0, 0, 1, 32'h0600_0000, 0, 1);
        exp_at(c, K_RDATA, 0); exp_at(c, K_RERR, 0);
        exp_at(c, K_EVALID, 0); exp_at(c, K_ECNT, 0);
        exp_at(c, K_EADDR, 0); exp_at(c, K_EWR, 0);
        tick; c = cyc;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_at(c, K_RDATA, 0); exp_at(c, K_RERR, 0);
        exp_at(c, K_ECNT, 0);  exp_at(c, K_EVALID, 0);
        exp_at(c, K_B_ECNT, 0);
        tick;
        tick;
        done = 1'b1;
        tick;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_xbar.md
Name: dbus_xbar

Overview:
Parametrised CPU data-bus interconnect. Replaces the per-slave read/write bus shims and the hand-written one-hot read mux with one block.
- Decodes the CPU read and write channels onto N memory-mapped slaves.
- Returns read data with a registered one-cycle select.
- Detects accesses to unmapped addresses and logs them in sticky error-status outputs.
- Sits between the riscv dmem ports and all data-side slaves (IRAM port B, DRAM, UART, SEG, SEC_CLK, BUTTON, and future ones).

Parameters:
NSLAVE, 6, number of slaves (1..16)
BASEADDR_WIDTH, 8, number of upper address bits compared against each base address
BASEADDRS, {32'h0500_0000,...,32'h0000_0000}, packed NSLAVE*32; slave i base at bits [32i+31:32i]
SLAVE_AW, {8'd4,8'd4,8'd4,8'd8,8'd14,8'd14}, packed NSLAVE*8; slave i offset width (1..32-BASEADDR_WIDTH)
STRICT, 1, 1 = address bits between SLAVE_AW and the base field must be zero for a hit; 0 = those bits are ignored (aliasing)
ERR_DATA, 32'hDEAD_BEEF, value returned on an unmapped read
ERRCNT_W, 16, width of the error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
m_wr  in  1  CPU write strobe
m_waddr  in  32  CPU write address
m_wdata  in  32  CPU write data
m_wstrb  in  4  CPU byte strobes
m_rd  in  1  CPU read strobe
m_raddr  in  32  CPU read address
m_rdata  out  32  read data, valid the cycle after m_rd
m_rerr  out  1  high with m_rdata when that read missed
s_wr  out  NSLAVE  per-slave write strobe
s_waddr  out  32  write offset, masked to the selected slave's SLAVE_AW
s_wdata  out  32  broadcast write data
s_wstrb  out  4  broadcast byte strobes
s_rd  out  NSLAVE  per-slave read strobe
s_raddr  out  32  read offset, masked to the selected slave's SLAVE_AW
s_rdata  in  NSLAVE*32  slave read data, 1-cycle latency
err_clr  in  1  clears the error-status outputs
err_valid  out  1  sticky: an error has occurred since reset/clear
err_addr  out  32  address of the first error since reset/clear
err_wr  out  1  that first error was a write
err_cnt  out  ERRCNT_W  saturating error count

Behaviour:
- One clock, clk. rst is synchronous and active-high. No asynchronous logic.
- Hit rule for slave i: addr[31:32-BASEADDR_WIDTH] equals base_i[31:32-BASEADDR_WIDTH]. If STRICT=1, addr[31-BASEADDR_WIDTH:SLAVE_AW_i] must also be zero.
- Overlapping hits: the lowest index wins. s_wr and s_rd are always one-hot or zero.
- Write path is fully combinational, zero latency.
  - s_wr[i] = m_wr & hit_w[i] & ~rst.
  - s_waddr = m_waddr & mask(SLAVE_AW of the winner); 0 when there is no hit.
- Read issue is combinational: s_rd[i] = m_rd & hit_r[i] & ~rst, with s_raddr masked the same way.
- Read select register rsel (index plus state NONE/HIT/MISS) is updated every edge:
  - m_rd with a hit → HIT(i).
  - m_rd with no hit → MISS.
  - no m_rd → NONE.
- Read return is combinational from rsel:
  - HIT(i): m_rdata = s_rdata[i], m_rerr = 0.
  - MISS: m_rdata = ERR_DATA, m_rerr = 1.
  - NONE: m_rdata = 0, m_rerr = 0.
- Back-to-back reads are supported every cycle. A read and a write in the same cycle are independent, including to the same slave.
- Error event: m_wr with no hit (werr) and/or m_rd with no hit (rerr).
  - err_cnt increments by werr+rerr each cycle and saturates at all-ones.
  - err_addr/err_wr load only when err_valid=0 (first error). If werr and rerr occur together, the write is captured.
  - err_valid is set by any error.
- err_clr clears err_valid, err_cnt and err_addr at the edge. If an error occurs in the same cycle, the new error is applied after the clear: count = 1 or 2, address captured, valid = 1.
- Reset at the edge where rst=1: rsel = NONE, err_valid = 0, err_addr = 0, err_wr = 0, err_cnt = 0.
  - While rst=1, s_wr and s_rd are 0.
  - A read issued the cycle before rst asserts still returns its data in the rst cycle; rsel is NONE afterwards.
- Errors are not counted while rst=1.

Decomposition:
- Package dbus_pkg holds:
  - DATA_W=32 and ADDR_W=32.
  - Default base-address constants: IRAM 0x0000_0000, DRAM 0x0100_0000, UART 0x0200_0000, SEG 0x0300_0000, SEC_CLK 0x0400_0000, BUTTON 0x0500_0000.
  - Default offset widths.
  - The rsel state encoding (NONE/HIT/MISS).
  - DEFAULT_ERR_DATA.
- Sub-module dbus_decode: combinational address decoder producing a one-hot hit vector, hit flag and masked offset. It is instantiated twice, once for the read channel and once for the write channel.

Test Plan:
- Default params; read 0x0100_0010 with DRAM returning 0x1234_5678 → s_rd=6'b000010, s_raddr=0x10; next cycle m_rdata=0x1234_5678, m_rerr=0.
- Write 0x0300_0004, wstrb=4'hF, wdata=0xA5 → in the same cycle s_wr=6'b001000, s_waddr=0x4, s_wdata=0xA5; no other s_wr bit set.
- STRICT=1, read 0x0300_0100 (SEG_AW=4) → s_rd=0; next cycle m_rdata=0xDEAD_BEEF, m_rerr=1, err_valid=1, err_addr=0x0300_0100, err_wr=0, err_cnt=1. The same access with STRICT=0 → hits SEG with offset 0x0.
- Same cycle: write 0x0700_0000 and read 0x0800_0000 → err_cnt +2, err_addr=0x0700_0000, err_wr=1. Then err_clr together with another miss read 0x0900_0000 → err_cnt=1, err_addr=0x0900_0000, err_valid=1.
- ERRCNT_W=2: issue 5 unmapped writes → err_cnt stays at 3. A back-to-back read stream IRAM→UART→miss→DRAM → returned data and m_rerr track each slave one cycle later.
- Issue a read to UART, assert rst on the next cycle → UART data is returned in the rst cycle; afterwards m_rdata=0, s_rd=s_wr=0 while rst=1, and all err_* outputs are 0.
